// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the shared RAM.
// slave: the arbiter's view. master: the environment (caches + RAM model).
interface mem_arbiter_if #(parameter int DATA_W = 32);
  logic              iREN;
  logic [DATA_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [DATA_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [DATA_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramrdy;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter for a single-ported RAM; data side has priority.
// Define MEM_ARBITER_STARVE_EN to force an instruction grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t state;
  state_t next_state;
  logic   d_req;
  logic   force_i;

  assign d_req     = bus.dREN | bus.dWEN;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

`ifdef MEM_ARBITER_STARVE_EN
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;

  assign force_i = bus.iREN && (starve_cnt == 4'(STARVE_MAX));

  // Counts data grants taken while a fetch waits; a fetch grant or idle icache clears it.
  always_comb begin
    starve_nxt = starve_cnt;
    if (state == IDLE) begin
      if (!bus.iREN || next_state == IACC)
        starve_nxt = 4'd0;
      else if (next_state == DACC && starve_cnt != 4'(STARVE_MAX))
        starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_cnt <= 4'd0;
    else       starve_cnt <= starve_nxt;
  end
`else
  assign force_i = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      IDLE: begin
        if (d_req && !force_i) next_state = DACC;
        else if (bus.iREN)     next_state = IACC;
      end
      DACC: begin
        // A dropped request aborts: no strobes, and any ramrdy is ignored.
        if (d_req) begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          if (bus.ramrdy) begin
            bus.dwait  = 1'b0;
            next_state = IDLE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      IACC: begin
        if (bus.iREN) begin
          bus.ramaddr = bus.iaddr;
          bus.ramREN  = 1'b1;
          if (bus.ramrdy) begin
            bus.iwait  = 1'b0;
            next_state = IDLE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
